// File: rtl/sample_capture.sv
// Capture engine: samples one synchronized pin, packs 16 samples per word into a buffer, drains it word by word.
// Optional 3-tap majority glitch filter on the sampled pin, enabled by defining CAPTURE_FILTER_EN.
module sample_capture #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_in,
    input  logic                  arm,
    input  logic [1:0]            trig_mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rd_req,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   wr_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_prev_s;
    logic [PRESCALE_W-1:0]   r_presc;
    logic [PRESCALE_W-1:0]   r_pcnt;
    logic [15:0]             r_shift;
    logic [3:0]              r_bitcnt;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [CW-1:0]           r_wr_count;
    logic [15:0]             r_mem [DEPTH];
    logic [15:0]             r_ram_q;
    logic                    r_rd_pend;
    logic [15:0]             r_rd_data;
    logic                    r_rd_valid;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_s;
    logic                    w_active;
    logic                    w_tick;
    logic                    w_trig;
    logic                    w_start;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [15:0]             w_word;
    logic [CW-1:0]           w_wc_inc;

    // Two-flop synchronizer for the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sample_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CAPTURE_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    // Majority of the last three synchronized values rejects single-cycle glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= 2'b00;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
            r_filt <= (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
        end
    end

    assign w_s = r_filt;
`else
    assign w_s = r_sync2;
`endif

    assign w_active = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign w_tick   = w_active && (r_pcnt == r_presc);
    assign w_start  = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_word   = {w_s, r_shift[15:1]};
    assign w_wc_inc = r_wr_count + CW'(1);
    assign w_wr_en  = (r_state == S_CAPTURE) && w_tick && (r_bitcnt == 4'd15);
    assign w_rd_en  = (r_state == S_DONE) && rd_req && !arm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Trigger evaluation and next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_trig      = 1'b0;
        case (trig_mode)
            2'b00:   w_trig = 1'b1;
            2'b01:   w_trig = !r_prev_s && w_s;
            2'b10:   w_trig = r_prev_s && !w_s;
            default: w_trig = w_s;
        endcase
        case (r_state)
            S_IDLE:    if (arm) w_state_nxt = S_ARMED;
            S_ARMED:   if (w_tick && w_trig) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (w_wr_en && (w_wc_inc == CW'(DEPTH))) w_state_nxt = S_DONE;
            S_DONE:    if (arm) w_state_nxt = S_ARMED;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_s   <= 1'b0;
            r_presc    <= '0;
            r_pcnt     <= '0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_count <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_start) begin
                r_presc    <= prescale;
                r_pcnt     <= '0;
                r_shift    <= '0;
                r_bitcnt   <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_wr_count <= '0;
                r_prev_s   <= w_s;
            end else if (w_active) begin
                r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_W'(1);
                if (w_tick) begin
                    r_prev_s <= w_s;
                end
                // The triggering sample is kept as sample 0 of the first word
                if (w_tick && (r_state == S_ARMED) && w_trig) begin
                    r_shift  <= w_word;
                    r_bitcnt <= 4'd1;
                end
                if (w_tick && (r_state == S_CAPTURE)) begin
                    r_shift  <= w_word;
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
                if (w_wr_en) begin
                    r_wr_ptr   <= r_wr_ptr + DEPTH_LOG2'(1);
                    r_wr_count <= w_wc_inc;
                end
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            r_rd_pend  <= w_rd_en;
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_rd_data <= r_ram_q;
            end
            r_busy <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    // Block-RAM style buffer with registered read port
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_word;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_ptr];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with a 4-word buffer: vector table of captures plus corner-case sequences.
module tb_sample_capture;

    logic        clk;
    logic        reset;
    logic        sample_in;
    logic        arm;
    logic [1:0]  trig_mode;
    logic [7:0]  prescale;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [2:0]  wr_count;

    int checks;
    int failures;
    int rv_cnt;

    logic [2:0] h_wc   [0:511];
    logic       h_busy [0:511];
    logic       h_done [0:511];

    typedef struct {
        logic            tog;
        logic            first;
        int              p;
        logic [7:0]      psc;
        logic [1:0]      mode;
        int              arm2;
        int              exp_done;
        logic [3:0][15:0] w;
    } vec_t;

    vec_t tbl [8];

    sample_capture #(.DEPTH_LOG2(2), .PRESCALE_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_in (sample_in),
        .arm       (arm),
        .trig_mode (trig_mode),
        .prescale  (prescale),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample value driven at negedge n becomes capture sample n once triggered at the first tick.
    task automatic capture(input logic tog, input logic first, input int p, input logic [7:0] psc,
                           input logic [1:0] mode, input int arm2_at, input int rst_at,
                           input int bound, output int done_n);
        done_n    = -1;
        rv_cnt    = 0;
        trig_mode = mode;
        prescale  = psc;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            h_wc[n]   = wr_count;
            h_busy[n] = busy;
            h_done[n] = done;
            if (n >= 3 && rd_valid) rv_cnt++;
            if (rst_at >= 0 && n == rst_at + 1) begin
                done_n = n;
                break;
            end
            if (rst_at < 0 && n >= 3 && done) begin
                done_n = n;
                break;
            end
            sample_in = tog ? (first ^ n[0]) : ((n < p) ? first : ~first);
            arm       = (n == 1) || (n == arm2_at);
            prescale  = (n <= 1) ? psc : 8'h07;
            rd_req    = (n == 20);
            reset     = (n == rst_at);
        end
        arm    = 1'b0;
        rd_req = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic read_one(input string name, input logic [15:0] exp);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        chk({name, "_early"}, rd_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, rd_valid, 1);
        chk({name, "_data"}, rd_data, exp);
        @(negedge clk);
        chk({name, "_drop"}, rd_valid, 0);
    endtask

    initial begin
        int dn;
        int got;
        logic [3:0][15:0] bw;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        sample_in = 1'b0;
        arm = 1'b0;
        trig_mode = 2'b00;
        prescale = 8'd0;
        rd_req = 1'b0;

        tbl[0] = '{tog:1'b0, first:1'b1, p:1000, psc:8'd0, mode:2'b00, arm2:-1, exp_done:66,
                   w:{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
        tbl[1] = '{tog:1'b1, first:1'b1, p:0,    psc:8'd0, mode:2'b00, arm2:-1, exp_done:66,
                   w:{16'h5555, 16'h5555, 16'h5555, 16'h5555}};
        tbl[2] = '{tog:1'b1, first:1'b0, p:0,    psc:8'd0, mode:2'b00, arm2:-1, exp_done:66,
                   w:{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA}};
        tbl[3] = '{tog:1'b0, first:1'b1, p:16,   psc:8'd0, mode:2'b00, arm2:-1, exp_done:66,
                   w:{16'h0000, 16'h0000, 16'h0000, 16'hFFFF}};
        tbl[4] = '{tog:1'b0, first:1'b1, p:16,   psc:8'd0, mode:2'b00, arm2:30, exp_done:66,
                   w:{16'h0000, 16'h0000, 16'h0000, 16'hFFFF}};
        tbl[5] = '{tog:1'b0, first:1'b0, p:20,   psc:8'd1, mode:2'b11, arm2:-1, exp_done:150,
                   w:{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
        tbl[6] = '{tog:1'b0, first:1'b1, p:10,   psc:8'd0, mode:2'b10, arm2:-1, exp_done:76,
                   w:{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        tbl[7] = '{tog:1'b0, first:1'b0, p:40,   psc:8'd3, mode:2'b01, arm2:-1, exp_done:298,
                   w:{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};

        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_count", wr_count, 0);
        reset = 1'b0;

        // Table of captures; each row is drained with five single reads (fifth wraps to word 0)
        for (int r = 0; r < 8; r++) begin
            capture(tbl[r].tog, tbl[r].first, tbl[r].p, tbl[r].psc, tbl[r].mode,
                    tbl[r].arm2, -1, 400, dn);
            chk($sformatf("row%0d_done_cycle", r), dn, tbl[r].exp_done);
            chk($sformatf("row%0d_wr_count", r), wr_count, 4);
            chk($sformatf("row%0d_busy", r), busy, 0);
            chk($sformatf("row%0d_early_rd_valid", r), rv_cnt, 0);
            for (int i = 0; i < 5; i++) begin
                read_one($sformatf("row%0d_rd%0d", r, i), tbl[r].w[i % 4]);
            end
        end

        // Edge trigger with prescale 3 (last table row): waiting, then writes every 4 clocks
        chk("edge_busy_wait", h_busy[40], 1);
        chk("edge_done_wait", h_done[40], 0);
        chk("edge_no_write_wait", h_wc[40], 0);
        chk("edge_first_write_pre", h_wc[105], 0);
        chk("edge_first_write", h_wc[106], 1);

        // Arm in DONE restarts; a coincident read is dropped
        @(negedge clk);
        arm = 1'b1;
        rd_req = 1'b1;
        prescale = 8'd0;
        trig_mode = 2'b00;
        sample_in = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        rd_req = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_wr_count", wr_count, 0);
        chk("restart_rd_valid0", rd_valid, 0);
        @(negedge clk);
        chk("restart_rd_valid1", rd_valid, 0);
        got = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("restart_completes", got, 1);
        chk("restart_wr_count_end", wr_count, 4);

        // Reset after 20 ticks aborts the capture
        capture(1'b0, 1'b1, 1000, 8'd0, 2'b00, -1, 22, 40, dn);
        chk("midrst_cycle", dn, 23);
        chk("midrst_wc_before", h_wc[22], 1);
        chk("midrst_busy", h_busy[23], 0);
        chk("midrst_done", h_done[23], 0);
        chk("midrst_wc", h_wc[23], 0);

        // Clean capture after reset, drained with back-to-back reads including the wrap
        capture(1'b0, 1'b1, 16, 8'd0, 2'b00, -1, -1, 100, dn);
        chk("postrst_done_cycle", dn, 66);
        chk("postrst_wr_count", wr_count, 4);
        bw = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        for (int m = 0; m < 8; m++) begin
            @(negedge clk);
            if (m >= 2 && m <= 6) begin
                chk($sformatf("b2b_valid%0d", m), rd_valid, 1);
                chk($sformatf("b2b_data%0d", m), rd_data, bw[(m - 2) % 4]);
            end else if (m == 1 || m == 7) begin
                chk($sformatf("b2b_idle%0d", m), rd_valid, 0);
            end
            rd_req = (m < 5);
        end
        rd_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
- Upstream capture engine for the SPI dump path. Samples one external pin, packs 16 consecutive samples into a word and stores words in an internal buffer.
- Arming and triggering are controlled by the SPI command handler.
- After capture, the command handler drains the buffer one 16-bit word per request and forwards each word to the SPI slave as reply data.

Parameters:
- DEPTH_LOG2, 8, log2 of buffer depth in 16-bit words (default 256 words, one 4K block RAM).
- PRESCALE_W, 8, width of the runtime prescale input.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_in  in  1  raw asynchronous input pin
- arm  in  1  single-cycle pulse; start a new capture
- trig_mode  in  2  00 immediate, 01 rising edge, 10 falling edge, 11 level high
- prescale  in  PRESCALE_W  sample tick every prescale+1 clk cycles; latched on arm
- rd_req  in  1  single-cycle pulse; request next stored word
- rd_data  out  16  word read from buffer
- rd_valid  out  1  one-cycle strobe qualifying rd_data
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- wr_count  out  DEPTH_LOG2+1  number of words written in current capture

Behaviour:
- Input conditioning: sample_in passes through a 2-FF synchronizer. Only the synchronized value (s) is used. A previous-s register supports edge detection.
- Reset: all outputs 0 (rd_data 0, rd_valid 0, busy 0, done 0, wr_count 0). State = IDLE. Pointers, prescale counter, shift register and bit counter are all 0. Reset mid-capture aborts to IDLE and discards the buffer contents logically; RAM contents need not be cleared.
- Prescale counter: runs only in ARMED and CAPTURE. A tick occurs when count == latched prescale; the counter then returns to 0. arm clears the counter, so the first tick falls prescale+1 cycles after arm.
- IDLE: arm -> ARMED, latch prescale, clear wr_count, write pointer and bit counter.
- ARMED: on each tick, evaluate the trigger using s and the previous s, both at tick time:
  - immediate: always true
  - rising: prev=0, s=1
  - falling: prev=1, s=0
  - level: s=1
  - When true, enter CAPTURE. The triggering sample is stored as sample 0.
- CAPTURE: on each tick, shift: word = {s, word[15:1]}, so sample 0 ends in bit 0 after 16 samples. On the 16th sample:
  - write the word to RAM[wr_ptr], increment wr_ptr and wr_count, clear the bit counter;
  - if wr_count reaches 2^DEPTH_LOG2, go to DONE.
- DONE: done=1. On entry the read pointer is 0.
  - rd_req reads RAM[rd_ptr] and increments rd_ptr.
  - rd_data and rd_valid appear exactly 2 cycles after rd_req (RAM output register plus output register); rd_data holds until the next read.
  - rd_ptr wraps from 2^DEPTH_LOG2-1 to 0.
  - Back-to-back rd_req on consecutive cycles is supported, giving one word per cycle.
- rd_req outside DONE: ignored, no rd_valid.
- arm in ARMED or CAPTURE: ignored. arm in DONE: restart (IDLE actions, go to ARMED), with rd_ptr reset. If arm and rd_req coincide in DONE, arm wins and that read is dropped.
- The prescale input is ignored except at arm.

Optional Feature:
- CAPTURE_FILTER_EN defined: a 3-tap majority filter (last three synchronized clk-rate values) feeds s, adding 2 cycles of input latency and rejecting single-cycle glitches.
- Undefined: s is the raw synchronizer output and no filter logic is present.

Test Plan:
- Fill, constant input: DEPTH_LOG2=2, prescale=0, mode 00, sample_in held 1, arm → done within 64+6 cycles, wr_count=4; four rd_req pulses → four rd_valid strobes, each rd_data=0xFFFF, valid 2 cycles after each req.
- Bit order: mode 00, prescale=0, sample_in toggles each cycle starting 1 at first tick → every word 0x5555; same pattern starting 0 → 0xAAAA.
- Edge trigger and prescale: prescale=3, mode 01, sample_in low for 40 cycles then high → busy during wait, no writes before the rise; word 0 bit 0 = 1; ticks every 4 cycles.
- Ignored and restart arm: arm pulse during CAPTURE → no change to wr_count progression. rd_req before done → no rd_valid. arm in DONE → done=0, wr_count=0, busy=1.
- Read wrap: DEPTH_LOG2=2, five rd_req after done → 5th rd_data equals word 0.
- Reset mid-capture: assert reset after 20 ticks → next cycle busy=0, done=0, wr_count=0; a following arm performs a clean full capture.
